// File: rtl/ptw_arbiter_if.sv
// TLB miss/refill ports and PTW request/result bundle for ptw_arbiter.
// slave = arbiter side, master = TLBs plus page table walker.
interface ptw_arbiter_if #(
    parameter int VPN_WIDTH  = 20,
    parameter int PPN_WIDTH  = 20,
    parameter int ASID_WIDTH = 8
);
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [VPN_WIDTH-1:0]  i_req_vpn;
    logic [ASID_WIDTH-1:0] i_req_asid;
    logic                  i_resp_valid;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [VPN_WIDTH-1:0]  d_req_vpn;
    logic [ASID_WIDTH-1:0] d_req_asid;
    logic                  d_resp_valid;

    logic                  resp_fault;
    logic [1:0]            resp_fault_type;
    logic [PPN_WIDTH-1:0]  resp_ppn;
    logic [3:0]            resp_flags;
    logic                  resp_global;

    logic                  ptw_request;
    logic [VPN_WIDTH-1:0]  ptw_vpn;
    logic [ASID_WIDTH-1:0] ptw_asid;
    logic                  ptw_done;
    logic                  ptw_fault;
    logic [1:0]            ptw_fault_type;
    logic [PPN_WIDTH-1:0]  ptw_result_ppn;
    logic [3:0]            ptw_result_flags;
    logic                  ptw_result_global;

    modport slave (
        input  i_req_valid, i_req_vpn, i_req_asid,
        input  d_req_valid, d_req_vpn, d_req_asid,
        input  ptw_done, ptw_fault, ptw_fault_type,
        input  ptw_result_ppn, ptw_result_flags, ptw_result_global,
        output i_req_ready, i_resp_valid,
        output d_req_ready, d_resp_valid,
        output resp_fault, resp_fault_type, resp_ppn,
        output resp_flags, resp_global,
        output ptw_request, ptw_vpn, ptw_asid
    );

    modport master (
        output i_req_valid, i_req_vpn, i_req_asid,
        output d_req_valid, d_req_vpn, d_req_asid,
        output ptw_done, ptw_fault, ptw_fault_type,
        output ptw_result_ppn, ptw_result_flags, ptw_result_global,
        input  i_req_ready, i_resp_valid,
        input  d_req_ready, d_resp_valid,
        input  resp_fault, resp_fault_type, resp_ppn,
        input  resp_flags, resp_global,
        input  ptw_request, ptw_vpn, ptw_asid
    );
endinterface

// File: rtl/ptw_arbiter.sv
// Round-robin arbiter sharing one page table walker between I-TLB and D-TLB.
// Define PTW_MERGE_EN to walk identical simultaneous misses only once.
module ptw_arbiter #(
    parameter int VPN_WIDTH  = 20,
    parameter int PPN_WIDTH  = 20,
    parameter int ASID_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    ptw_arbiter_if.slave  bus,
    output logic          arb_busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_next;

    logic                  rr_ptr;
    logic                  drop;
    logic                  own_i;
    logic                  own_d;
    logic [VPN_WIDTH-1:0]  vpn_q;
    logic [ASID_WIDTH-1:0] asid_q;

    logic                  fault_q;
    logic [1:0]            ftype_q;
    logic [PPN_WIDTH-1:0]  ppn_q;
    logic [3:0]            flags_q;
    logic                  global_q;

    logic merge;
    logic grant_i;
    logic grant_d;
    logic accept;
    logic capture;
    logic walk_end;
    logic i_ready;
    logic d_ready;
    logic i_resp;
    logic d_resp;
    logic request;

`ifdef PTW_MERGE_EN
    assign merge = bus.i_req_valid && bus.d_req_valid
                && (bus.i_req_vpn == bus.d_req_vpn)
                && (bus.i_req_asid == bus.d_req_asid);
`else
    assign merge = 1'b0;
`endif

    // rr_ptr only matters when both ports contend
    assign grant_i = bus.i_req_valid
                  && (!bus.d_req_valid || merge || !rr_ptr);
    assign grant_d = bus.d_req_valid
                  && (!bus.i_req_valid || merge || rr_ptr);

    assign walk_end = bus.ptw_done || bus.ptw_fault;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        request    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush && (grant_i || grant_d)) begin
                    accept     = 1'b1;
                    i_ready    = grant_i;
                    d_ready    = grant_d;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                request    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (walk_end) begin
                    if (drop || flush) begin
                        state_next = IDLE;
                    end else begin
                        capture    = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                i_resp     = own_i;
                d_resp     = own_d;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= 1'b0;
            drop     <= 1'b0;
            own_i    <= 1'b0;
            own_d    <= 1'b0;
            vpn_q    <= '0;
            asid_q   <= '0;
            fault_q  <= 1'b0;
            ftype_q  <= 2'b00;
            ppn_q    <= '0;
            flags_q  <= 4'b0000;
            global_q <= 1'b0;
        end else begin
            if (accept) begin
                own_i  <= grant_i;
                own_d  <= grant_d;
                vpn_q  <= grant_i ? bus.i_req_vpn : bus.d_req_vpn;
                asid_q <= grant_i ? bus.i_req_asid : bus.d_req_asid;
                if (!merge) rr_ptr <= grant_i;
            end
            if (state == WAIT && walk_end) begin
                drop <= 1'b0;
            end else if (flush && (state == ISSUE || state == WAIT)) begin
                drop <= 1'b1;
            end
            // fault has priority over done when both pulse together
            if (capture) begin
                fault_q  <= bus.ptw_fault;
                ftype_q  <= bus.ptw_fault ? bus.ptw_fault_type : 2'b00;
                ppn_q    <= bus.ptw_result_ppn;
                flags_q  <= bus.ptw_result_flags;
                global_q <= bus.ptw_result_global;
            end
        end
    end

    assign bus.i_req_ready     = i_ready;
    assign bus.d_req_ready     = d_ready;
    assign bus.i_resp_valid    = i_resp;
    assign bus.d_resp_valid    = d_resp;
    assign bus.resp_fault      = fault_q;
    assign bus.resp_fault_type = ftype_q;
    assign bus.resp_ppn        = ppn_q;
    assign bus.resp_flags      = flags_q;
    assign bus.resp_global     = global_q;
    assign bus.ptw_request     = request;
    assign bus.ptw_vpn         = vpn_q;
    assign bus.ptw_asid        = asid_q;
    assign arb_busy            = (state != IDLE);
endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: grant order, PTW latency, faults,
// flush drop, reset mid-walk and the optional merge of identical misses.
module tb_ptw_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic arb_busy;

    int total = 0;
    int bad = 0;
    int req_cnt = 0;
    int c0;

`ifdef PTW_MERGE_EN
    localparam logic MERGE = 1'b1;
`else
    localparam logic MERGE = 1'b0;
`endif

    always #5 clk = ~clk;

    ptw_arbiter_if bus ();

    ptw_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus.slave),
        .arb_busy (arb_busy)
    );

    always @(posedge clk) if (bus.ptw_request === 1'b1) req_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req_i(input logic v, input logic [19:0] vpn,
                         input logic [7:0] asid);
        bus.i_req_valid = v;
        bus.i_req_vpn   = vpn;
        bus.i_req_asid  = asid;
    endtask

    task automatic req_d(input logic v, input logic [19:0] vpn,
                         input logic [7:0] asid);
        bus.d_req_valid = v;
        bus.d_req_vpn   = vpn;
        bus.d_req_asid  = asid;
    endtask

    // one-cycle PTW result pulse, returns one cycle later
    task automatic pulse_ptw(input logic done, input logic fault,
                             input logic [1:0] ftype,
                             input logic [19:0] ppn,
                             input logic [3:0] flags, input logic g);
        bus.ptw_done          = done;
        bus.ptw_fault         = fault;
        bus.ptw_fault_type    = ftype;
        bus.ptw_result_ppn    = ppn;
        bus.ptw_result_flags  = flags;
        bus.ptw_result_global = g;
        tick();
        bus.ptw_done  = 1'b0;
        bus.ptw_fault = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        req_i(1'b0, 20'h0, 8'h0);
        req_d(1'b0, 20'h0, 8'h0);
        bus.ptw_done = 1'b0;
        bus.ptw_fault = 1'b0;
        bus.ptw_fault_type = 2'b00;
        bus.ptw_result_ppn = 20'h0;
        bus.ptw_result_flags = 4'h0;
        bus.ptw_result_global = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", arb_busy, 0);
        chk("rst_req", bus.ptw_request, 0);
        chk("rst_iresp", bus.i_resp_valid, 0);
        chk("rst_dresp", bus.d_resp_valid, 0);
        chk("rst_fault", bus.resp_fault, 0);
        chk("rst_ftype", bus.resp_fault_type, 0);
        chk("rst_ppn", bus.resp_ppn, 0);
        chk("rst_flags", bus.resp_flags, 0);
        chk("rst_glob", bus.resp_global, 0);

        // I-only miss, PTW answers 5 cycles after the request
        req_i(1'b1, 20'h12345, 8'h11);
        #1;
        chk("t1_iready", bus.i_req_ready, 1);
        chk("t1_dready", bus.d_req_ready, 0);
        tick();
        req_i(1'b0, 20'h0, 8'h0);
        chk("t1_req", bus.ptw_request, 1);
        chk("t1_vpn", bus.ptw_vpn, 20'h12345);
        chk("t1_asid", bus.ptw_asid, 8'h11);
        tick();
        chk("t1_req1", bus.ptw_request, 0);
        repeat (4) tick();
        chk("t1_busy", arb_busy, 1);
        pulse_ptw(1'b1, 1'b0, 2'b00, 20'hABCDE, 4'b1011, 1'b1);
        chk("t1_iresp", bus.i_resp_valid, 1);
        chk("t1_dresp", bus.d_resp_valid, 0);
        chk("t1_ppn", bus.resp_ppn, 20'hABCDE);
        chk("t1_flags", bus.resp_flags, 4'b1011);
        chk("t1_glob", bus.resp_global, 1);
        chk("t1_fault", bus.resp_fault, 0);
        chk("t1_ftype", bus.resp_fault_type, 0);
        tick();
        chk("t1_iresp_end", bus.i_resp_valid, 0);
        chk("t1_idle", arb_busy, 0);
        chk("t1_hold", bus.resp_ppn, 20'hABCDE);

        // contention after reset: I first, then D on the next contention
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_i(1'b1, 20'h1, 8'h0);
        req_d(1'b1, 20'h2, 8'h0);
        #1;
        chk("t2_iready", bus.i_req_ready, 1);
        chk("t2_dready", bus.d_req_ready, 0);
        tick();
        req_i(1'b0, 20'h0, 8'h0);
        #1;
        chk("t2_vpn1", bus.ptw_vpn, 20'h1);
        chk("t2_dbusy", bus.d_req_ready, 0);
        tick();
        pulse_ptw(1'b1, 1'b0, 2'b00, 20'h00111, 4'h1, 1'b0);
        chk("t2_iresp", bus.i_resp_valid, 1);
        chk("t2_dresp0", bus.d_resp_valid, 0);
        tick();
        req_i(1'b1, 20'h3, 8'h0);
        #1;
        chk("t2_dwins", bus.d_req_ready, 1);
        chk("t2_ilose", bus.i_req_ready, 0);
        tick();
        req_d(1'b0, 20'h0, 8'h0);
        #1;
        chk("t2_vpn2", bus.ptw_vpn, 20'h2);
        tick();
        pulse_ptw(1'b1, 1'b0, 2'b00, 20'h00222, 4'h3, 1'b0);
        chk("t2_dresp", bus.d_resp_valid, 1);
        chk("t2_iresp0", bus.i_resp_valid, 0);
        chk("t2_ppn2", bus.resp_ppn, 20'h00222);
        tick();
        chk("t2_iheld", bus.i_req_ready, 1);
        tick();
        req_i(1'b0, 20'h0, 8'h0);
        #1;
        chk("t2_vpn3", bus.ptw_vpn, 20'h3);
        tick();
        pulse_ptw(1'b1, 1'b0, 2'b00, 20'h00333, 4'h7, 1'b0);
        chk("t2_iresp3", bus.i_resp_valid, 1);
        tick();

        // D miss with page fault, then done+fault together
        req_d(1'b1, 20'h55, 8'h22);
        #1;
        chk("t3_dready", bus.d_req_ready, 1);
        tick();
        req_d(1'b0, 20'h0, 8'h0);
        tick();
        pulse_ptw(1'b0, 1'b1, 2'b01, 20'h0, 4'h0, 1'b0);
        chk("t3_dresp", bus.d_resp_valid, 1);
        chk("t3_iresp", bus.i_resp_valid, 0);
        chk("t3_fault", bus.resp_fault, 1);
        chk("t3_ftype", bus.resp_fault_type, 2'b01);
        tick();
        chk("t3_idle", arb_busy, 0);
        req_i(1'b1, 20'h66, 8'h0);
        tick();
        req_i(1'b0, 20'h0, 8'h0);
        tick();
        pulse_ptw(1'b1, 1'b1, 2'b10, 20'h04444, 4'h0, 1'b0);
        chk("t3_both_resp", bus.i_resp_valid, 1);
        chk("t3_both_fault", bus.resp_fault, 1);
        chk("t3_both_ftype", bus.resp_fault_type, 2'b10);
        chk("t3_both_ppn", bus.resp_ppn, 20'h04444);
        tick();

        // flush mid-walk drops the result; held D is served afterwards
        req_i(1'b1, 20'h77, 8'h0);
        tick();
        req_i(1'b0, 20'h0, 8'h0);
        req_d(1'b1, 20'h88, 8'h3);
        #1;
        chk("t4_dwait", bus.d_req_ready, 0);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        pulse_ptw(1'b1, 1'b0, 2'b00, 20'hFFFFF, 4'hF, 1'b1);
        chk("t4_noiresp", bus.i_resp_valid, 0);
        chk("t4_nodresp", bus.d_resp_valid, 0);
        chk("t4_idle", arb_busy, 0);
        chk("t4_nocap", bus.resp_ppn, 20'h04444);
        chk("t4_dready", bus.d_req_ready, 1);
        flush = 1'b1;
        #1;
        chk("t4_fl_idle", bus.d_req_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("t4_fl_noacc", arb_busy, 0);
        chk("t4_dready2", bus.d_req_ready, 1);
        tick();
        req_d(1'b0, 20'h0, 8'h0);
        chk("t4_vpn", bus.ptw_vpn, 20'h88);
        tick();
        pulse_ptw(1'b1, 1'b0, 2'b00, 20'h00888, 4'h5, 1'b0);
        flush = 1'b1;
        #1;
        chk("t4_resp_fl", bus.d_resp_valid, 1);
        tick();
        flush = 1'b0;
        pulse_ptw(1'b1, 1'b0, 2'b00, 20'h01234, 4'h2, 1'b0);
        chk("t4_stray_busy", arb_busy, 0);
        chk("t4_stray_resp", bus.i_resp_valid | bus.d_resp_valid, 0);
        chk("t4_stray_ppn", bus.resp_ppn, 20'h00888);

        // reset during WAIT
        req_i(1'b1, 20'h99, 8'h0);
        tick();
        req_i(1'b0, 20'h0, 8'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_busy", arb_busy, 0);
        chk("t5_req", bus.ptw_request, 0);
        chk("t5_ppn", bus.resp_ppn, 0);
        chk("t5_fault", bus.resp_fault, 0);
        chk("t5_flags", bus.resp_flags, 0);
        rst = 1'b0;
        pulse_ptw(1'b1, 1'b0, 2'b00, 20'h00999, 4'h1, 1'b0);
        chk("t5_noresp", bus.i_resp_valid, 0);
        chk("t5_idle", arb_busy, 0);
        tick();

        // identical misses: merged (one walk) or serialized (two walks)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c0 = req_cnt;
        req_i(1'b1, 20'h00400, 8'h05);
        req_d(1'b1, 20'h00400, 8'h05);
        #1;
        chk("t6_iready", bus.i_req_ready, 1);
        chk("t6_dready", bus.d_req_ready, {31'd0, MERGE});
        tick();
        req_i(1'b0, 20'h0, 8'h0);
        if (MERGE) req_d(1'b0, 20'h0, 8'h0);
        tick();
        pulse_ptw(1'b1, 1'b0, 2'b00, 20'h0400A, 4'h3, 1'b0);
        chk("t6_iresp", bus.i_resp_valid, 1);
        chk("t6_dresp", bus.d_resp_valid, {31'd0, MERGE});
        tick();
        if (!MERGE) begin
            chk("t6_dready2", bus.d_req_ready, 1);
            tick();
            req_d(1'b0, 20'h0, 8'h0);
            tick();
            pulse_ptw(1'b1, 1'b0, 2'b00, 20'h0400A, 4'h3, 1'b0);
            chk("t6_dresp2", bus.d_resp_valid, 1);
            tick();
        end
        chk("t6_walks", req_cnt - c0, MERGE ? 1 : 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
